// File: rtl/vx_axi_wburst_sched.sv
// vx_axi_wburst_sched: two-input AXI4 write scheduler with round-robin AW grant, W burst lock and tagged B steering
module vx_axi_wburst_sched #(
    parameter int AXI_DATA_WIDTH  = 512,
    parameter int AXI_ADDR_WIDTH  = 64,
    parameter int AXI_TID_WIDTH   = 8,
    parameter int TAG_SEL_IDX     = 0,
    parameter int MAX_OUTSTANDING = 4,
    localparam int CW = $clog2(MAX_OUTSTANDING + 1),
    localparam int IW = AXI_TID_WIDTH + 1
) (
    input  logic                                  clk,
    input  logic                                  reset_n,
    input  logic [1:0]                            m_axi_awvalid_i,
    input  logic [1:0][AXI_ADDR_WIDTH-1:0]        m_axi_awaddr_i,
    input  logic [1:0][AXI_TID_WIDTH-1:0]         m_axi_awid_i,
    input  logic [1:0][7:0]                       m_axi_awlen_i,
    input  logic [1:0][2:0]                       m_axi_awsize_i,
    input  logic [1:0][1:0]                       m_axi_awburst_i,
    input  logic [1:0][1:0]                       m_axi_awlock_i,
    input  logic [1:0][3:0]                       m_axi_awcache_i,
    input  logic [1:0][2:0]                       m_axi_awprot_i,
    input  logic [1:0][3:0]                       m_axi_awqos_i,
    input  logic [1:0][3:0]                       m_axi_awregion_i,
    output logic [1:0]                            m_axi_awready_i,
    input  logic [1:0]                            m_axi_wvalid_i,
    input  logic [1:0][AXI_DATA_WIDTH-1:0]        m_axi_wdata_i,
    input  logic [1:0][AXI_DATA_WIDTH/8-1:0]      m_axi_wstrb_i,
    input  logic [1:0]                            m_axi_wlast_i,
    output logic [1:0]                            m_axi_wready_i,
    output logic [1:0]                            m_axi_bvalid_i,
    output logic [1:0][AXI_TID_WIDTH-1:0]         m_axi_bid_i,
    output logic [1:0][1:0]                       m_axi_bresp_i,
    input  logic [1:0]                            m_axi_bready_i,
    output logic                                  m_axi_awvalid,
    output logic [AXI_ADDR_WIDTH-1:0]             m_axi_awaddr,
    output logic [IW-1:0]                         m_axi_awid,
    output logic [7:0]                            m_axi_awlen,
    output logic [2:0]                            m_axi_awsize,
    output logic [1:0]                            m_axi_awburst,
    output logic [1:0]                            m_axi_awlock,
    output logic [3:0]                            m_axi_awcache,
    output logic [2:0]                            m_axi_awprot,
    output logic [3:0]                            m_axi_awqos,
    output logic [3:0]                            m_axi_awregion,
    input  logic                                  m_axi_awready,
    output logic                                  m_axi_wvalid,
    output logic [AXI_DATA_WIDTH-1:0]             m_axi_wdata,
    output logic [AXI_DATA_WIDTH/8-1:0]           m_axi_wstrb,
    output logic                                  m_axi_wlast,
    input  logic                                  m_axi_wready,
    input  logic                                  m_axi_bvalid,
    input  logic [IW-1:0]                         m_axi_bid,
    input  logic [1:0]                            m_axi_bresp,
    output logic                                  m_axi_bready,
    output logic [1:0][CW-1:0]                    outstanding_i,
    output logic                                  err
);
    typedef enum logic [1:0] {S_IDLE, S_AW, S_DATA} state_t;

    localparam logic [IW-1:0] LO = IW'((1 << TAG_SEL_IDX) - 1);

    state_t           state_q;
    logic             g_q, p_q, err_q;
    logic [7:0]       beat_q, len_q;
    logic [1:0][CW-1:0] cnt_q, cnt_d;
    logic [1:0]       elig, g_oh, sel_oh;
    logic             aw_hs, w_hs, b_hs, last, sel, underflow;
    logic [IW-1:0]    id_ext;

    assign sel    = m_axi_bid[TAG_SEL_IDX];
    assign g_oh   = g_q ? 2'b10 : 2'b01;
    assign sel_oh = sel ? 2'b10 : 2'b01;
    assign last   = beat_q == len_q;
    assign aw_hs  = state_q == S_AW && m_axi_awvalid_i[g_q] && m_axi_awready;
    assign w_hs   = state_q == S_DATA && m_axi_wvalid_i[g_q] && m_axi_wready;
    assign b_hs   = m_axi_bvalid && m_axi_bready;
    assign underflow = cnt_q[sel] == '0;

    assign m_axi_awvalid   = state_q == S_AW && m_axi_awvalid_i[g_q];
    assign m_axi_awaddr    = m_axi_awaddr_i[g_q];
    assign m_axi_awlen     = m_axi_awlen_i[g_q];
    assign m_axi_awsize    = m_axi_awsize_i[g_q];
    assign m_axi_awburst   = m_axi_awburst_i[g_q];
    assign m_axi_awlock    = m_axi_awlock_i[g_q];
    assign m_axi_awcache   = m_axi_awcache_i[g_q];
    assign m_axi_awprot    = m_axi_awprot_i[g_q];
    assign m_axi_awqos     = m_axi_awqos_i[g_q];
    assign m_axi_awregion  = m_axi_awregion_i[g_q];
    assign id_ext          = {1'b0, m_axi_awid_i[g_q]};
    assign m_axi_awid      = ((id_ext & ~LO) << 1) | (id_ext & LO) | (IW'(g_q) << TAG_SEL_IDX);
    assign m_axi_awready_i = (state_q == S_AW && m_axi_awready) ? g_oh : 2'b00;

    assign m_axi_wvalid    = state_q == S_DATA && m_axi_wvalid_i[g_q];
    assign m_axi_wdata     = m_axi_wdata_i[g_q];
    assign m_axi_wstrb     = m_axi_wstrb_i[g_q];
    assign m_axi_wlast     = state_q == S_DATA && last;
    assign m_axi_wready_i  = (state_q == S_DATA && m_axi_wready) ? g_oh : 2'b00;

    assign m_axi_bvalid_i  = m_axi_bvalid ? sel_oh : 2'b00;
    assign m_axi_bid_i     = {2{AXI_TID_WIDTH'(((m_axi_bid >> 1) & ~LO) | (m_axi_bid & LO))}};
    assign m_axi_bresp_i   = {2{m_axi_bresp}};
    assign m_axi_bready    = m_axi_bready_i[sel];

    assign outstanding_i   = cnt_q;
    assign err             = err_q;

    // eligibility and outstanding-count update; simultaneous AW and B on one input cancel out
    always_comb begin
        cnt_d = cnt_q;
        elig  = 2'b00;
        for (int s = 0; s < 2; s++) begin
            elig[s] = m_axi_awvalid_i[s] && cnt_q[s] < CW'(MAX_OUTSTANDING);
            if (aw_hs && g_q == 1'(s) && !(b_hs && sel == 1'(s)))
                cnt_d[s] = cnt_q[s] + CW'(1);
            else if (b_hs && sel == 1'(s) && !(aw_hs && g_q == 1'(s)) && cnt_q[s] != '0)
                cnt_d[s] = cnt_q[s] - CW'(1);
        end
    end

    // grant FSM, burst tracking and sticky protocol error
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            g_q     <= 1'b0;
            p_q     <= 1'b0;
            beat_q  <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            if ((b_hs && (underflow || m_axi_bresp != 2'b00)) || (w_hs && m_axi_wlast_i[g_q] != last))
                err_q <= 1'b1;
            case (state_q)
                S_IDLE: if (|elig) begin
                    g_q     <= elig[p_q] ? p_q : ~p_q;
                    state_q <= S_AW;
                end
                S_AW: if (aw_hs) begin
                    len_q   <= m_axi_awlen_i[g_q];
                    beat_q  <= '0;
                    state_q <= S_DATA;
                end
                S_DATA: if (w_hs) begin
                    beat_q <= beat_q + 8'd1;
                    if (last) begin
                        p_q     <= ~g_q;
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_vx_axi_wburst_sched.sv
// tb_vx_axi_wburst_sched: table-driven cycle vectors plus directed corner sequences for the write scheduler
module tb_vx_axi_wburst_sched;
    localparam int DW = 32;
    localparam int AWD = 64;
    localparam int TW = 8;
    localparam int CW = 2;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]               awvalid_i, awready_i, wvalid_i, wlast_i, wready_i, bvalid_i, bready_i;
    logic [1:0][AWD-1:0]      awaddr_i;
    logic [1:0][TW-1:0]       awid_i, bid_i;
    logic [1:0][7:0]          awlen_i;
    logic [1:0][2:0]          awsize_i, awprot_i;
    logic [1:0][1:0]          awburst_i, awlock_i, bresp_i;
    logic [1:0][3:0]          awcache_i, awqos_i, awregion_i;
    logic [1:0][DW-1:0]       wdata_i;
    logic [1:0][DW/8-1:0]     wstrb_i;
    logic                     awvalid, awready, wvalid, wlast, wready, bvalid, bready, err;
    logic [AWD-1:0]           awaddr;
    logic [TW:0]              awid, bid;
    logic [7:0]               awlen;
    logic [2:0]               awsize, awprot;
    logic [1:0]               awburst, awlock, bresp;
    logic [3:0]               awcache, awqos, awregion;
    logic [DW-1:0]            wdata;
    logic [DW/8-1:0]          wstrb;
    logic [1:0][CW-1:0]       outstanding;

    vx_axi_wburst_sched #(
        .AXI_DATA_WIDTH(DW), .AXI_ADDR_WIDTH(AWD), .AXI_TID_WIDTH(TW),
        .TAG_SEL_IDX(0), .MAX_OUTSTANDING(2)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .m_axi_awvalid_i(awvalid_i), .m_axi_awaddr_i(awaddr_i), .m_axi_awid_i(awid_i),
        .m_axi_awlen_i(awlen_i), .m_axi_awsize_i(awsize_i), .m_axi_awburst_i(awburst_i),
        .m_axi_awlock_i(awlock_i), .m_axi_awcache_i(awcache_i), .m_axi_awprot_i(awprot_i),
        .m_axi_awqos_i(awqos_i), .m_axi_awregion_i(awregion_i), .m_axi_awready_i(awready_i),
        .m_axi_wvalid_i(wvalid_i), .m_axi_wdata_i(wdata_i), .m_axi_wstrb_i(wstrb_i),
        .m_axi_wlast_i(wlast_i), .m_axi_wready_i(wready_i),
        .m_axi_bvalid_i(bvalid_i), .m_axi_bid_i(bid_i), .m_axi_bresp_i(bresp_i),
        .m_axi_bready_i(bready_i),
        .m_axi_awvalid(awvalid), .m_axi_awaddr(awaddr), .m_axi_awid(awid), .m_axi_awlen(awlen),
        .m_axi_awsize(awsize), .m_axi_awburst(awburst), .m_axi_awlock(awlock),
        .m_axi_awcache(awcache), .m_axi_awprot(awprot), .m_axi_awqos(awqos),
        .m_axi_awregion(awregion), .m_axi_awready(awready),
        .m_axi_wvalid(wvalid), .m_axi_wdata(wdata), .m_axi_wstrb(wstrb), .m_axi_wlast(wlast),
        .m_axi_wready(wready),
        .m_axi_bvalid(bvalid), .m_axi_bid(bid), .m_axi_bresp(bresp), .m_axi_bready(bready),
        .outstanding_i(outstanding), .err(err)
    );

    typedef struct {
        logic        rst;
        logic [1:0]  awv, wv, wl, bri;
        logic        bv;
        logic [8:0]  bid;
        logic [7:0]  len;
        logic [31:0] exp;
    } vec_t;

    vec_t tv[$];
    int n_chk = 0;
    int n_fail = 0;
    logic [31:0] obs;

    // packed view of the observed outputs; awid and bid only matter while their valid is high
    assign obs = {awvalid, awvalid ? awid : 9'h0, wvalid, wlast, awready_i, wready_i, bvalid_i,
                  (|bvalid_i) ? bid_i[bvalid_i[1]] : 8'h0, bready, outstanding[0], outstanding[1], err};

    function automatic vec_t mk(input logic rst, input logic [1:0] awv, wv, wl, input logic bv,
                                input logic [8:0] b_id, input logic [1:0] bri, input logic [7:0] len,
                                input logic e_awv, input logic [8:0] e_awid, input logic e_wv, e_wl,
                                input logic [1:0] e_awr, e_wr, e_bv, input logic [7:0] e_bid,
                                input logic e_br, input logic [1:0] e_c0, e_c1, input logic e_err);
        vec_t v;
        v.rst = rst; v.awv = awv; v.wv = wv; v.wl = wl; v.bv = bv; v.bid = b_id; v.bri = bri; v.len = len;
        v.exp = {e_awv, e_awid, e_wv, e_wl, e_awr, e_wr, e_bv, e_bid, e_br, e_c0, e_c1, e_err};
        return v;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        awvalid_i = '0; wvalid_i = '0; wlast_i = '0; bready_i = '0; awlen_i = '0;
        bvalid = 1'b0; bid = '0; bresp = 2'b00; awready = 1'b1; wready = 1'b1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        clear_inputs();
        tick();
        reset_n = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        awaddr_i = {64'h2000, 64'h1000}; awid_i = {8'h33, 8'h5A};
        awsize_i = {3'd2, 3'd2}; awburst_i = {2'b01, 2'b01}; awlock_i = '0; awcache_i = '0;
        awprot_i = '0; awqos_i = '0; awregion_i = '0;
        wdata_i = {32'hBBBB_0001, 32'hAAAA_0000}; wstrb_i = {4'hF, 4'hF};
        clear_inputs();
        // reset with a B presented: the combinational B path still steers it
        tv.push_back(mk(1, 0, 0, 0, 1, 9'h0B4, 0, 0,  0, 0, 0, 0, 0, 0, 2'b01, 8'h5A, 0, 0, 0, 0));
        // single input 0 burst, awlen=3
        tv.push_back(mk(0, 0, 0, 0, 0, 0, 0, 3,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tv.push_back(mk(0, 2'b01, 0, 0, 0, 0, 0, 3,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tv.push_back(mk(0, 2'b01, 0, 0, 0, 0, 0, 3,  1, 9'h0B4, 0, 0, 2'b01, 0, 0, 0, 0, 0, 0, 0));
        tv.push_back(mk(0, 0, 2'b01, 0, 0, 0, 0, 3,  0, 0, 1, 0, 0, 2'b01, 0, 0, 0, 1, 0, 0));
        tv.push_back(mk(0, 0, 2'b01, 0, 0, 0, 0, 3,  0, 0, 1, 0, 0, 2'b01, 0, 0, 0, 1, 0, 0));
        tv.push_back(mk(0, 0, 2'b01, 0, 0, 0, 0, 3,  0, 0, 1, 0, 0, 2'b01, 0, 0, 0, 1, 0, 0));
        tv.push_back(mk(0, 0, 2'b01, 2'b01, 0, 0, 0, 3,  0, 0, 1, 1, 0, 2'b01, 0, 0, 0, 1, 0, 0));
        tv.push_back(mk(0, 0, 0, 0, 1, 9'h0B4, 2'b01, 3,  0, 0, 0, 0, 0, 0, 2'b01, 8'h5A, 1, 1, 0, 0));
        tv.push_back(mk(0, 0, 0, 0, 0, 0, 0, 3,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tv.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        // both inputs busy, awlen=0: alternating grants until both hit the outstanding limit
        tv.push_back(mk(0, 2'b11, 2'b11, 2'b11, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tv.push_back(mk(0, 2'b11, 2'b11, 2'b11, 0, 0, 0, 0,  1, 9'h0B4, 0, 0, 2'b01, 0, 0, 0, 0, 0, 0, 0));
        tv.push_back(mk(0, 2'b11, 2'b11, 2'b11, 0, 0, 0, 0,  0, 0, 1, 1, 0, 2'b01, 0, 0, 0, 1, 0, 0));
        tv.push_back(mk(0, 2'b11, 2'b11, 2'b11, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0));
        tv.push_back(mk(0, 2'b11, 2'b11, 2'b11, 0, 0, 0, 0,  1, 9'h067, 0, 0, 2'b10, 0, 0, 0, 0, 1, 0, 0));
        tv.push_back(mk(0, 2'b11, 2'b11, 2'b11, 0, 0, 0, 0,  0, 0, 1, 1, 0, 2'b10, 0, 0, 0, 1, 1, 0));
        tv.push_back(mk(0, 2'b11, 2'b11, 2'b11, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0));
        tv.push_back(mk(0, 2'b11, 2'b11, 2'b11, 0, 0, 0, 0,  1, 9'h0B4, 0, 0, 2'b01, 0, 0, 0, 0, 1, 1, 0));
        tv.push_back(mk(0, 2'b11, 2'b11, 2'b11, 0, 0, 0, 0,  0, 0, 1, 1, 0, 2'b01, 0, 0, 0, 2, 1, 0));
        tv.push_back(mk(0, 2'b11, 2'b11, 2'b11, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0, 0, 2, 1, 0));
        tv.push_back(mk(0, 2'b11, 2'b11, 2'b11, 0, 0, 0, 0,  1, 9'h067, 0, 0, 2'b10, 0, 0, 0, 0, 2, 1, 0));
        tv.push_back(mk(0, 2'b11, 2'b11, 2'b11, 0, 0, 0, 0,  0, 0, 1, 1, 0, 2'b10, 0, 0, 0, 2, 2, 0));
        tv.push_back(mk(0, 2'b11, 2'b11, 2'b11, 1, 9'h067, 2'b10, 0,  0, 0, 0, 0, 0, 0, 2'b10, 8'h33, 1, 2, 2, 0));
        tv.push_back(mk(0, 2'b11, 2'b11, 2'b11, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0, 0, 2, 1, 0));
        tv.push_back(mk(0, 2'b11, 2'b11, 2'b11, 0, 0, 0, 0,  1, 9'h067, 0, 0, 2'b10, 0, 0, 0, 0, 2, 1, 0));
        tv.push_back(mk(0, 2'b11, 2'b11, 2'b11, 0, 0, 0, 0,  0, 0, 1, 1, 0, 2'b10, 0, 0, 0, 2, 2, 0));
        tv.push_back(mk(0, 2'b11, 2'b11, 2'b11, 1, 9'h0B4, 2'b01, 0,  0, 0, 0, 0, 0, 0, 2'b01, 8'h5A, 1, 2, 2, 0));
        tv.push_back(mk(0, 2'b11, 2'b11, 2'b11, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2, 0));
        tv.push_back(mk(0, 2'b11, 2'b11, 2'b11, 0, 0, 0, 0,  1, 9'h0B4, 0, 0, 2'b01, 0, 0, 0, 0, 1, 2, 0));
        tv.push_back(mk(0, 2'b11, 2'b11, 2'b11, 0, 0, 0, 0,  0, 0, 1, 1, 0, 2'b01, 0, 0, 0, 2, 2, 0));
        tv.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0, 0, 2, 2, 0));
        tv.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        // input 1 raises wlast on beat 1 of a 4-beat burst: sticky err, downstream wlast still on beat 3
        tv.push_back(mk(0, 2'b10, 0, 0, 0, 0, 0, 3,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tv.push_back(mk(0, 2'b10, 0, 0, 0, 0, 0, 3,  1, 9'h067, 0, 0, 2'b10, 0, 0, 0, 0, 0, 0, 0));
        tv.push_back(mk(0, 0, 2'b10, 0, 0, 0, 0, 3,  0, 0, 1, 0, 0, 2'b10, 0, 0, 0, 0, 1, 0));
        tv.push_back(mk(0, 0, 2'b10, 2'b10, 0, 0, 0, 3,  0, 0, 1, 0, 0, 2'b10, 0, 0, 0, 0, 1, 0));
        tv.push_back(mk(0, 0, 2'b10, 0, 0, 0, 0, 3,  0, 0, 1, 0, 0, 2'b10, 0, 0, 0, 0, 1, 1));
        tv.push_back(mk(0, 0, 2'b10, 0, 0, 0, 0, 3,  0, 0, 1, 1, 0, 2'b10, 0, 0, 0, 0, 1, 1));
        tv.push_back(mk(0, 0, 0, 0, 0, 0, 0, 3,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1));

        tick();
        foreach (tv[i]) begin
            reset_n = !tv[i].rst;
            awvalid_i = tv[i].awv; wvalid_i = tv[i].wv; wlast_i = tv[i].wl;
            bvalid = tv[i].bv; bid = tv[i].bid; bready_i = tv[i].bri; awlen_i = {tv[i].len, tv[i].len};
            #3;
            chk($sformatf("vec%0d", i), 64'(obs), 64'(tv[i].exp));
            tick();
        end

        // B to an input with nothing outstanding
        do_reset();
        bvalid = 1'b1; bid = 9'h0B4; bready_i = 2'b01;
        tick();
        bvalid = 1'b0; bready_i = 2'b00;
        chk("underflow_err", 64'(err), 64'd1);
        chk("underflow_cnt", 64'(outstanding[0]), 64'd0);

        // SLVERR response on a legitimately outstanding write
        do_reset();
        awvalid_i = 2'b01; wvalid_i = 2'b01; wlast_i = 2'b01;
        tick(); tick(); tick();
        awvalid_i = 2'b00; wvalid_i = 2'b00;
        chk("bresp_pre_cnt", 64'(outstanding[0]), 64'd1);
        chk("bresp_pre_err", 64'(err), 64'd0);
        bvalid = 1'b1; bid = 9'h0B4; bresp = 2'b10; bready_i = 2'b01;
        tick();
        bvalid = 1'b0; bready_i = 2'b00; bresp = 2'b00;
        chk("bresp_err", 64'(err), 64'd1);
        chk("bresp_cnt", 64'(outstanding[0]), 64'd0);

        // asynchronous reset during beat 2 of a 4-beat burst
        do_reset();
        awvalid_i = 2'b01; awlen_i = {8'd3, 8'd3}; wvalid_i = 2'b01;
        tick(); tick(); tick(); tick();
        chk("midrst_pre_wvalid", 64'({wvalid, wready_i}), 64'({1'b1, 2'b01}));
        chk("midrst_pre_wdata", 64'(wdata), 64'h0000_0000_AAAA_0000);
        #2 reset_n = 1'b0;
        #1;
        chk("midrst_drop", 64'({awvalid, wvalid, awready_i, wready_i}), 64'd0);
        chk("midrst_cnt", 64'(outstanding), 64'd0);
        #1 reset_n = 1'b1;
        awvalid_i = 2'b11; wvalid_i = 2'b00;
        tick();
        chk("midrst_regrant", 64'({awvalid, awid, awready_i}), 64'({1'b1, 9'h0B4, 2'b01}));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
